// File: rtl/ccff_pkg.sv
// Shared types, CRC constants and the bit-serial CRC step for the ccff chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } ccff_state_e;

  localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
  localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

  // CRC-16-CCITT, one bit per step, MSB-first register.
  function automatic logic [15:0] ccff_crc_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that accepts bitstream words and presents them LSB-first, one bit per shift.
module ccff_word_serializer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              clear,
  input  logic              shift,
  input  logic [CNT_W-1:0]  bits_left,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              head_bit,
  output logic              nonempty
);

  localparam int unsigned BCNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic              accept;

  // Refill while the last buffered bit leaves so a held s_valid streams without bubbles;
  // never fetch a word whose bits would all be discarded.
  assign s_ready  = active
                  && ((cnt_q == '0) || ((cnt_q == BCNT_W'(1)) && shift))
                  && (32'(bits_left) > 32'(cnt_q));
  assign accept   = s_valid && s_ready;
  assign head_bit = word_q[0];
  assign nonempty = (cnt_q != '0);

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      word_d = s_data;
      cnt_d  = BCNT_W'(WORD_W);
    end else if (shift) begin
      word_d = word_q >> 1;
      cnt_d  = cnt_q - BCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a ccff shift chain from a word stream, then optionally rotates it once
// and compares the CRC of what comes back against the CRC of what was sent.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d;
  logic [15:0]      crc_load_q, crc_load_d;
  logic [15:0]      crc_chk_q, crc_chk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic buf_nonempty, buf_head, shift, clear;

  assign shift     = (state_q == LOAD) && buf_nonempty && (bits_left_q != '0);
  assign clear     = (state_d != LOAD);
  assign ccff_en   = shift || (state_q == VERIFY);
  assign ccff_head = shift ? buf_head : ((state_q == VERIFY) ? ccff_tail : 1'b0);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clk       (prog_clk),
    .rst_n     (prog_reset_n),
    .active    (state_q == LOAD),
    .clear     (clear),
    .shift     (shift),
    .bits_left (bits_left_q),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .head_bit  (buf_head),
    .nonempty  (buf_nonempty)
  );

  // The bit counter is reused to time the rotation pass.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    crc_load_d  = crc_load_q;
    crc_chk_d   = crc_chk_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d       = 1'b0;
          bits_left_d = CNT_W'(CHAIN_LEN);
          crc_load_d  = CCFF_CRC_INIT;
          crc_chk_d   = CCFF_CRC_INIT;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (shift) begin
          bits_left_d = bits_left_q - CNT_W'(1);
          crc_load_d  = ccff_crc_step(crc_load_q, buf_head);
        end
        if (bits_left_d == '0) begin
          state_d     = VERIFY_EN ? VERIFY : DONE;
          bits_left_d = VERIFY_EN ? CNT_W'(CHAIN_LEN) : '0;
        end
      end
      VERIFY: begin
        crc_chk_d = ccff_crc_step(crc_chk_q, ccff_tail);
        if (bits_left_q <= CNT_W'(1)) begin
          bits_left_d = '0;
          state_d     = DONE;
        end else begin
          bits_left_d = bits_left_q - CNT_W'(1);
        end
      end
      DONE: begin
        err_d   = VERIFY_EN && (crc_chk_q != crc_load_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == VERIFY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      crc_load_q  <= CCFF_CRC_INIT;
      crc_chk_q   <= CCFF_CRC_INIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      crc_load_q  <= crc_load_d;
      crc_chk_q   <= crc_chk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural shift-chain models on two instances
// (verify pass on and off), randomized words and stall gaps, fault and reset scenarios.
module tb_ccff_chain_loader;

  localparam int unsigned N  = 20;
  localparam int unsigned W  = 8;
  localparam int unsigned NB = 8;

  logic prog_clk = 1'b0;
  logic prog_reset_n = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic         start_a = 1'b0, s_valid_a = 1'b0, s_ready_a, head_a, en_a, tail_a, busy_a, done_a, err_a;
  logic [W-1:0] s_data_a = '0;
  logic         start_b = 1'b0, s_valid_b = 1'b0, s_ready_b, head_b, en_b, tail_b, busy_b, done_b, err_b;
  logic [W-1:0] s_data_b = '0;

  logic [N-1:0]  chain_a = '0;
  logic [N-1:0]  fault_mask = '0;
  logic [NB-1:0] chain_b = '0;

  ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W), .VERIFY_EN(1'b1)) dut_a (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_a), .s_data(s_data_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .ccff_head(head_a), .ccff_en(en_a),
    .ccff_tail(tail_a), .busy(busy_a), .done(done_a), .err(err_a));

  ccff_chain_loader #(.CHAIN_LEN(NB), .WORD_W(W), .VERIFY_EN(1'b0)) dut_b (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_b), .s_data(s_data_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .ccff_head(head_b), .ccff_en(en_b),
    .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .err(err_b));

  // Chain models: index 0 is the head flop, the top index is the tail flop.
  assign tail_a = chain_a[N-1];
  assign tail_b = chain_b[NB-1];
  always @(posedge prog_clk) begin
    if (en_a) chain_a <= {chain_a[N-2:0], head_a} ^ fault_mask;
    if (en_b) chain_b <= {chain_b[NB-2:0], head_b};
  end

  int asserts = 0;
  int fails   = 0;

  logic [W-1:0] words[$];
  logic         loaded[$];
  int   n_en, n_stall, head_bad, ready_bad, n_done, cyc_done, n_acc;
  logic err_pre, err_c1, err_post;
  bit   timed_out, reset_hit;

  // Bitstream bit j is bit (j mod W) of word j/W, words sent in order.
  function automatic logic [N-1:0] model_stream();
    logic [N-1:0] v;
    logic [W-1:0] w;
    for (int j = 0; j < int'(N); j++) begin
      w    = words[j / W];
      v[j] = w[j % W];
    end
    return v;
  endfunction

  // After N shifts the first streamed bit sits at the tail.
  function automatic logic [N-1:0] model_chain();
    logic [N-1:0] s, c;
    s = model_stream();
    for (int j = 0; j < int'(N); j++) c[N-1-j] = s[j];
    return c;
  endfunction

  function automatic logic [N-1:0] got_load();
    logic [N-1:0] v;
    v = 'x;
    for (int j = 0; j < loaded.size() && j < int'(N); j++) v[j] = loaded[j];
    return v;
  endfunction

  task automatic random_words();
    words.delete();
    repeat (4) words.push_back(W'($urandom));
  endtask

  // Drive one start on instance A and collect observations until shortly after done.
  task automatic run_a(input int gap, input int fault_at, input int reset_at, input int start_mid_at);
    int  gapcnt;
    int  wi;
    int  post;
    bit  armed;
    gapcnt = 0; wi = 0; post = 0; armed = (gap > 0);
    n_en = 0; n_stall = 0; head_bad = 0; ready_bad = 0; n_done = 0; cyc_done = -1;
    reset_hit = 0; err_c1 = 1'bx; err_post = 1'bx;
    loaded.delete();
    @(negedge prog_clk);
    err_pre = err_a;
    start_a = 1'b1;
    for (int c = 1; c < 400; c++) begin
      @(negedge prog_clk);
      fault_mask = '0;
      start_a    = 1'b0;
      if (c == 1) err_c1 = err_a;
      if (en_a) begin
        if (n_en < int'(N)) loaded.push_back(head_a);
        else begin
          if (head_a !== tail_a) head_bad++;
          if (n_en - int'(N) == fault_at) fault_mask[7] = 1'b1;
        end
        n_en++;
      end else begin
        if (head_a !== 1'b0) head_bad++;
        if (busy_a) n_stall++;
      end
      if (!busy_a && s_ready_a) ready_bad++;
      if (done_a) begin n_done++; cyc_done = c; end
      if (n_done > 0) post++;
      if (post == 2) err_post = err_a;
      if (reset_at >= 0 && en_a && n_en == reset_at) begin
        prog_reset_n = 1'b0;
        s_valid_a    = 1'b0;
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        reset_hit    = 1;
        n_acc        = wi;
        return;
      end
      if (c == start_mid_at || c == start_mid_at + int'(N)) start_a = 1'b1;
      if (armed && wi == 1 && s_ready_a) begin gapcnt = gap; armed = 0; end
      if (gapcnt > 0) begin s_valid_a = 1'b0; gapcnt--; end
      else s_valid_a = (wi < words.size());
      s_data_a = (wi < words.size()) ? words[wi] : W'($urandom);
      if (s_valid_a && s_ready_a) wi++;
      if (post > 3) break;
    end
    s_valid_a = 1'b0;
    n_acc     = wi;
    timed_out = (n_done == 0);
  endtask

  task automatic test_reset();
    prog_reset_n = 1'b0;
    repeat (3) @(negedge prog_clk);
    asserts++; if (s_ready_a !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b expected 0", s_ready_a); end
    asserts++; if (en_a !== 1'b0) begin fails++; $display("FAIL reset_ccff_en: got %b expected 0", en_a); end
    asserts++; if (head_a !== 1'b0) begin fails++; $display("FAIL reset_ccff_head: got %b expected 0", head_a); end
    asserts++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    asserts++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done_a); end
    asserts++; if (err_a !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_a); end
    asserts++; if ({busy_b, en_b, s_ready_b, err_b} !== 4'b0) begin fails++; $display("FAIL reset_b_outputs: got %b expected 0000", {busy_b, en_b, s_ready_b, err_b}); end
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
  endtask

  task automatic test_stream();
    words = '{8'h5A, 8'hC3, 8'h0F, 8'hFF};
    run_a(0, -1, -1, -1);
    asserts++; if (timed_out) begin fails++; $display("FAIL stream_timeout: got no done expected done"); end
    asserts++; if (n_en !== 2 * int'(N)) begin fails++; $display("FAIL stream_en_count: got %0d expected %0d", n_en, 2 * N); end
    asserts++; if (cyc_done !== 2 * int'(N) + 2) begin fails++; $display("FAIL stream_done_cycle: got %0d expected %0d", cyc_done, 2 * N + 2); end
    asserts++; if (got_load() !== model_stream()) begin fails++; $display("FAIL stream_bits: got %h expected %h", got_load(), model_stream()); end
    asserts++; if (chain_a !== model_chain()) begin fails++; $display("FAIL stream_chain: got %h expected %h", chain_a, model_chain()); end
    asserts++; if (err_post !== 1'b0) begin fails++; $display("FAIL stream_err: got %b expected 0", err_post); end
    // Only the initial word-fetch cycle is busy without a shift.
    asserts++; if (n_stall !== 1) begin fails++; $display("FAIL stream_stalls: got %0d expected 1", n_stall); end
    asserts++; if (n_acc !== 3) begin fails++; $display("FAIL stream_words_taken: got %0d expected 3", n_acc); end
    asserts++; if (head_bad !== 0 || ready_bad !== 0) begin fails++; $display("FAIL stream_head_ready: got %0d/%0d expected 0/0", head_bad, ready_bad); end
  endtask

  task automatic test_stall();
    words = '{8'h5A, 8'hC3, 8'h0F, 8'h00};
    run_a(5, -1, -1, -1);
    asserts++; if (n_stall !== 1 + 5) begin fails++; $display("FAIL stall_cycles: got %0d expected 6", n_stall); end
    asserts++; if (head_bad !== 0) begin fails++; $display("FAIL stall_head_zero: got %0d bad cycles expected 0", head_bad); end
    asserts++; if (n_en !== 2 * int'(N)) begin fails++; $display("FAIL stall_en_count: got %0d expected %0d", n_en, 2 * N); end
    asserts++; if (cyc_done !== 2 * int'(N) + 2 + 5) begin fails++; $display("FAIL stall_done_cycle: got %0d expected %0d", cyc_done, 2 * N + 7); end
    asserts++; if (chain_a !== model_chain() || err_post !== 1'b0) begin fails++; $display("FAIL stall_result: got chain %h err %b expected %h err 0", chain_a, err_post, model_chain()); end
  endtask

  task automatic test_fault();
    random_words();
    run_a(0, 2, -1, -1);
    asserts++; if (n_done !== 1) begin fails++; $display("FAIL fault_done_count: got %0d expected 1", n_done); end
    asserts++; if (err_post !== 1'b1) begin fails++; $display("FAIL fault_err: got %b expected 1", err_post); end
    repeat (6) @(negedge prog_clk);
    asserts++; if (err_a !== 1'b1) begin fails++; $display("FAIL fault_err_sticky: got %b expected 1", err_a); end
    random_words();
    run_a(0, -1, -1, -1);
    asserts++; if (err_pre !== 1'b1 || err_c1 !== 1'b0) begin fails++; $display("FAIL fault_err_clear: got before %b after %b expected 1 then 0", err_pre, err_c1); end
    asserts++; if (err_post !== 1'b0 || chain_a !== model_chain()) begin fails++; $display("FAIL fault_recover: got err %b chain %h expected 0 %h", err_post, chain_a, model_chain()); end
  endtask

  task automatic test_reset_mid();
    random_words();
    run_a(0, -1, 10, -1);
    asserts++; if (!reset_hit) begin fails++; $display("FAIL rstmid_reached: got no reset expected reset at bit 10"); end
    asserts++; if ({busy_a, en_a, s_ready_a, err_a, done_a} !== 5'b0) begin fails++; $display("FAIL rstmid_outputs: got %b expected 00000", {busy_a, en_a, s_ready_a, err_a, done_a}); end
    random_words();
    run_a(0, -1, -1, -1);
    asserts++; if (cyc_done !== 2 * int'(N) + 2 || err_post !== 1'b0) begin fails++; $display("FAIL rstmid_rerun: got done %0d err %b expected %0d 0", cyc_done, err_post, 2 * N + 2); end
    asserts++; if (chain_a !== model_chain()) begin fails++; $display("FAIL rstmid_chain: got %h expected %h", chain_a, model_chain()); end
  endtask

  task automatic test_start_ignored();
    int extra;
    random_words();
    run_a(0, -1, -1, 5);
    extra = 0;
    repeat (8) begin
      @(negedge prog_clk);
      if (done_a || busy_a) extra++;
    end
    asserts++; if (n_done !== 1 || extra !== 0) begin fails++; $display("FAIL ignore_start_done: got %0d dones %0d extra busy/done expected 1 0", n_done, extra); end
    asserts++; if (cyc_done !== 2 * int'(N) + 2) begin fails++; $display("FAIL ignore_start_timing: got %0d expected %0d", cyc_done, 2 * N + 2); end
  endtask

  task automatic test_random();
    int gap;
    for (int it = 0; it < 4; it++) begin
      random_words();
      gap = int'($urandom_range(0, 4));
      run_a(gap, -1, -1, -1);
      asserts++; if (cyc_done !== 2 * int'(N) + 2 + gap || n_en !== 2 * int'(N)) begin fails++; $display("FAIL random_timing it%0d: got done %0d en %0d expected %0d %0d", it, cyc_done, n_en, 2 * N + 2 + gap, 2 * N); end
      asserts++; if (chain_a !== model_chain() || err_post !== 1'b0) begin fails++; $display("FAIL random_chain it%0d: got %h err %b expected %h err 0", it, chain_a, err_post, model_chain()); end
      asserts++; if (n_acc !== 3 || head_bad !== 0 || ready_bad !== 0) begin fails++; $display("FAIL random_proto it%0d: got words %0d head %0d ready %0d expected 3 0 0", it, n_acc, head_bad, ready_bad); end
    end
  endtask

  task automatic test_no_verify();
    logic [W-1:0]  w;
    logic [NB-1:0] exp_chain;
    int   nen, ndone, cdone, acc;
    logic errb;
    for (int it = 0; it < 2; it++) begin
      w = (it == 0) ? 8'hA5 : W'($urandom);
      for (int j = 0; j < int'(NB); j++) exp_chain[NB-1-j] = w[j];
      nen = 0; ndone = 0; cdone = -1; acc = 0; errb = 1'bx;
      @(negedge prog_clk);
      start_b = 1'b1;
      for (int c = 1; c < 20; c++) begin
        @(negedge prog_clk);
        start_b = 1'b0;
        if (en_b) nen++;
        if (done_b) begin ndone++; cdone = c; end
        if (cdone > 0 && c == cdone + 1) errb = err_b;
        s_valid_b = 1'b1;
        s_data_b  = (acc == 0) ? w : W'($urandom);
        if (s_valid_b && s_ready_b) acc++;
      end
      s_valid_b = 1'b0;
      asserts++; if (nen !== int'(NB) || acc !== 1) begin fails++; $display("FAIL noverify_shifts it%0d: got %0d shifts %0d words expected %0d 1", it, nen, acc, NB); end
      asserts++; if (cdone !== int'(NB) + 2 || ndone !== 1) begin fails++; $display("FAIL noverify_done it%0d: got cycle %0d count %0d expected %0d 1", it, cdone, ndone, NB + 2); end
      asserts++; if (chain_b !== exp_chain || errb !== 1'b0) begin fails++; $display("FAIL noverify_chain it%0d: got %h err %b expected %h err 0", it, chain_b, errb, exp_chain); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_fault();
    test_reset_mid();
    test_start_ignored();
    test_random();
    test_no_verify();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected end of test");
    $fatal(1);
  end

endmodule
